// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: op/state encodings and op-class helpers shared by the multiply/divide unit
package ex_muldiv_pkg;
  localparam int MD_OPW = 3;
  typedef enum logic [MD_OPW-1:0] {
    MD_MUL, MD_MULH, MD_MULHU, MD_DIV, MD_MOD, MD_DIVU, MD_MODU, MD_RSVD
  } md_op_e;
  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX, MD_DONE} md_state_e;
  function automatic logic md_is_div(input logic [MD_OPW-1:0] op);
    return op == MD_DIV || op == MD_MOD || op == MD_DIVU || op == MD_MODU;
  endfunction
  function automatic logic md_is_signed(input logic [MD_OPW-1:0] op);
    return op == MD_MUL || op == MD_MULH || op == MD_DIV || op == MD_MOD;
  endfunction
  function automatic logic md_is_quot(input logic [MD_OPW-1:0] op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction
endpackage

// File: rtl/ex_muldiv_step.sv
// ex_muldiv_step: one radix-2 shift-add (multiply) or restoring subtract (divide) iteration
module ex_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_n,
  output logic [XLEN-1:0] lo_n
);
  logic [XLEN:0]   sum;
  logic [XLEN:0]   sh;
  logic [XLEN-1:0] diff;
  logic            ok;
  assign sum  = {1'b0, hi} + {1'b0, b & {XLEN{lo[0]}}};
  // XLEN+1-bit partial remainder; when the subtract succeeds the difference always fits in XLEN bits
  assign sh   = {hi, lo[XLEN-1]};
  assign ok   = sh >= {1'b0, b};
  assign diff = sh[XLEN-1:0] - b;
  always_comb begin
    hi_n = div ? (ok ? diff : sh[XLEN-1:0]) : sum[XLEN:1];
    lo_n = div ? {lo[XLEN-2:0], ok} : {sum[0], lo[XLEN-1:1]};
  end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative EX-stage multiply/divide unit with valid/ready handshakes and flush.
// Define MULDIV_FAST_MUL_EN to compute multiplies combinationally at accept (IDLE -> FIX -> DONE).
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [MD_OPW-1:0] req_op_i,
  input  logic [XLEN-1:0]   req_opd1_i,
  input  logic [XLEN-1:0]   req_opd2_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  input  logic              flush_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [XLEN-1:0]   resp_result_o,
  output logic [TAG_W-1:0]  resp_tag_o,
  output logic              busy_o
);
  localparam int CW = $clog2(XLEN) + 1;
  md_state_e         state, state_n;
  logic [MD_OPW-1:0] op;
  logic [TAG_W-1:0]  tag;
  logic              neg;
  logic [XLEN-1:0]   hi, lo, b, result, hi_n, lo_n;
  logic [CW-1:0]     cnt;
  logic              accept, div_op, s1, s2, dz, ovf, special, last, fast;
  logic [XLEN-1:0]   m1, m2, spec_res, fix_res, q_s, r_s;
  logic [2*XLEN-1:0] prod_s;
  assign accept  = req_valid_i && state == MD_IDLE && !flush_i;
  assign div_op  = md_is_div(req_op_i);
  assign s1      = md_is_signed(req_op_i) && req_opd1_i[XLEN-1];
  assign s2      = md_is_signed(req_op_i) && req_opd2_i[XLEN-1];
  assign m1      = s1 ? -req_opd1_i : req_opd1_i;
  assign m2      = s2 ? -req_opd2_i : req_opd2_i;
  assign dz      = div_op && req_opd2_i == '0;
  assign ovf     = (req_op_i == MD_DIV || req_op_i == MD_MOD) &&
                   req_opd1_i == {1'b1, {(XLEN-1){1'b0}}} && &req_opd2_i;
  assign special = dz || ovf || req_op_i == MD_RSVD;
  assign last    = cnt == CW'(XLEN - 1);
  // Divide-by-zero wins over overflow: a zero divisor can never be -1
  assign spec_res = req_op_i == MD_RSVD ? '0 :
                    dz ? (md_is_quot(req_op_i) ? '1 : req_opd1_i) :
                    req_op_i == MD_DIV ? {1'b1, {(XLEN-1){1'b0}}} : '0;
`ifdef MULDIV_FAST_MUL_EN
  assign fast = !div_op;
`else
  assign fast = 1'b0;
`endif
  ex_muldiv_step #(.XLEN(XLEN)) u_step (
    .div  (md_is_div(op)),
    .hi   (hi),
    .lo   (lo),
    .b    (b),
    .hi_n (hi_n),
    .lo_n (lo_n)
  );
  always_comb begin
    prod_s  = neg ? -{hi, lo} : {hi, lo};
    q_s     = neg ? -lo : lo;
    r_s     = neg ? -hi : hi;
    fix_res = op == MD_MUL ? prod_s[XLEN-1:0] :
              (op == MD_MULH || op == MD_MULHU) ? prod_s[2*XLEN-1:XLEN] :
              md_is_quot(op) ? q_s : r_s;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= MD_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (flush_i) state_n = MD_IDLE;
    else
      case (state)
        MD_IDLE: if (accept) state_n = special ? MD_DONE : fast ? MD_FIX : MD_CALC;
        MD_CALC: if (last) state_n = MD_FIX;
        MD_FIX:  state_n = MD_DONE;
        MD_DONE: if (resp_ready_i) state_n = MD_IDLE;
        default: state_n = MD_IDLE;
      endcase
  end
  // Multiply keeps the multiplier in lo and adds b; divide shifts the dividend out of lo
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      op     <= '0;
      tag    <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      b      <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      op     <= req_op_i;
      tag    <= req_tag_i;
      neg    <= req_op_i == MD_MOD ? s1 : s1 ^ s2;
      b      <= div_op ? m2 : m1;
      cnt    <= '0;
`ifdef MULDIV_FAST_MUL_EN
      {hi, lo} <= div_op ? {{XLEN{1'b0}}, m1} : {{XLEN{1'b0}}, m1} * {{XLEN{1'b0}}, m2};
`else
      hi <= '0;
      lo <= div_op ? m1 : m2;
`endif
      if (special) result <= spec_res;
    end else if (state == MD_CALC) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + 1'b1;
    end else if (state == MD_FIX) result <= fix_res;
  assign req_ready_o   = state == MD_IDLE;
  assign resp_valid_o  = state == MD_DONE;
  assign busy_o        = state != MD_IDLE;
  assign resp_result_o = result;
  assign resp_tag_o    = tag;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed vector table plus handshake, flush and async-reset sequences for ex_muldiv
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;
`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 2;
`else
  localparam int ML = 34;
`endif
  logic        clk = 0, rst_n = 0, req_valid = 0, flush = 0, resp_ready = 0;
  logic [2:0]  req_op = '0;
  logic [31:0] opd1 = '0, opd2 = '0;
  logic [4:0]  req_tag = '0;
  logic        req_ready, resp_valid, busy;
  logic [31:0] resp_result;
  logic [4:0]  resp_tag;
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;
  ex_muldiv #(.XLEN(32), .TAG_W(5)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_op_i      (req_op),
    .req_opd1_i    (opd1),
    .req_opd2_i    (opd2),
    .req_tag_i     (req_tag),
    .flush_i       (flush),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_result_o (resp_result),
    .resp_tag_o    (resp_tag),
    .busy_o        (busy)
  );
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t v[19];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    req_valid = 1;
    req_op    = op;
    opd1      = a;
    opd2      = b;
    req_tag   = tag;
  endtask
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic consume, output int lat);
    @(negedge clk);
    drive(op, a, b, tag);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      req_valid = 0;
      lat++;
    end while (!resp_valid && lat < 100);
    if (consume) begin
      resp_ready = 1;
      @(posedge clk);
      #1;
      resp_ready = 0;
    end
  endtask
  initial begin
    int lat;
    logic seen;
    v[0]  = '{MD_MUL,   32'd7,        32'hFFFFFFFD, 5'd4,  32'hFFFFFFEB, ML};
    v[1]  = '{MD_MULH,  32'h80000000, 32'h80000000, 5'd1,  32'h40000000, ML};
    v[2]  = '{MD_MULHU, 32'hFFFFFFFF, 32'd2,        5'd2,  32'h00000001, ML};
    v[3]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        5'd3,  32'hFFFFFFFD, 34};
    v[4]  = '{MD_MOD,   32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFF, 34};
    v[5]  = '{MD_DIVU,  32'd100,      32'd7,        5'd6,  32'd14,       34};
    v[6]  = '{MD_MODU,  32'd100,      32'd7,        5'd7,  32'd2,        34};
    v[7]  = '{MD_DIV,   32'd5,        32'd0,        5'd8,  32'hFFFFFFFF, 1};
    v[8]  = '{MD_MOD,   32'd5,        32'd0,        5'd9,  32'd5,        1};
    v[9]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 1};
    v[10] = '{MD_MOD,   32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0,        1};
    v[11] = '{MD_RSVD,  32'd1,        32'd2,        5'd12, 32'd0,        1};
    v[12] = '{MD_DIVU,  32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1};
    v[13] = '{MD_MODU,  32'hFFFFFFFF, 32'h10,       5'd14, 32'hF,        34};
    v[14] = '{MD_DIVU,  32'hFFFFFFFF, 32'h10,       5'd15, 32'h0FFFFFFF, 34};
    v[15] = '{MD_MULH,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd16, 32'd0,        ML};
    v[16] = '{MD_MULH,  32'hFFFFFFFF, 32'd5,        5'd17, 32'hFFFFFFFF, ML};
    v[17] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 5'd18, 32'hFFFFFFFD, 34};
    v[18] = '{MD_MOD,   32'd7,        32'hFFFFFFFE, 5'd19, 32'd1,        34};
    repeat (3) @(posedge clk);
    #1;
    check("rst valid", resp_valid, 0);
    check("rst ready", req_ready, 1);
    check("rst busy", busy, 0);
    check("rst result", resp_result, 0);
    check("rst tag", resp_tag, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 19; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, v[i].tag, 1'b0, lat);
      check($sformatf("v%0d latency", i), lat, v[i].lat);
      check($sformatf("v%0d result", i), resp_result, v[i].exp);
      check($sformatf("v%0d tag", i), resp_tag, v[i].tag);
      resp_ready = 1;
      @(posedge clk);
      #1;
      resp_ready = 0;
      check($sformatf("v%0d released", i), {resp_valid, req_ready}, 2'b01);
    end
    run_op(MD_DIVU, 32'd100, 32'd7, 5'd9, 1'b0, lat);
    check("hold latency", lat, 34);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold %0d", i), {resp_valid, resp_tag, resp_result}, {1'b1, 5'd9, 32'd14});
    end
    drive(MD_MODU, 32'd100, 32'd7, 5'd10);
    resp_ready = 1;
    @(posedge clk);
    #1;
    resp_ready = 0;
    check("b2b idle", {resp_valid, req_ready, busy}, 3'b010);
    @(posedge clk);
    #1;
    req_valid = 0;
    check("b2b accepted", busy, 1);
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b latency", lat, 34);
    check("b2b result", {resp_tag, resp_result}, {5'd10, 32'd2});
    resp_ready = 1;
    @(posedge clk);
    #1;
    resp_ready = 0;
    run_op(MD_MUL, 32'd3, 32'd5, 5'd20, 1'b0, lat);
    check("pre-flush result", {resp_tag, resp_result}, {5'd20, 32'd15});
    resp_ready = 1;
    @(posedge clk);
    #1;
    resp_ready = 0;
    @(negedge clk);
    drive(MD_MUL, 32'd3, 32'd5, 5'd21);
    @(posedge clk);
    #1;
    req_valid = 0;
    repeat (10) @(posedge clk);
    #1;
    check("flush busy before", busy, 1);
    flush = 1;
    drive(MD_DIVU, 32'd1, 32'd0, 5'd22);
    @(posedge clk);
    #1;
    flush = 0;
    req_valid = 0;
    check("flush idle", {resp_valid, req_ready, busy}, 3'b010);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      seen |= resp_valid | busy;
    end
    check("flush no response", seen, 0);
    @(negedge clk);
    drive(MD_DIV, 32'd1000, 32'd3, 5'd23);
    @(posedge clk);
    #1;
    req_valid = 0;
    repeat (5) @(posedge clk);
    #2;
    check("pre-reset busy", busy, 1);
    rst_n = 0;
    #1;
    check("async rst state", {resp_valid, req_ready, busy}, 3'b010);
    check("async rst data", {resp_tag, resp_result}, 37'd0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      seen |= resp_valid;
    end
    check("reset no response", seen, 0);
    run_op(MD_DIV, 32'd1000, 32'd3, 5'd24, 1'b1, lat);
    check("after reset latency", lat, 34);
    check("after reset done", {resp_valid, req_ready}, 2'b01);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
